fpmul_rr_sched: RTL

Round-robin scheduler that shares one iterative single-precision FP multiplier between two requesters. It accepts an operand pair over a valid/ready handshake and drives the shared multiplier. It waits the multiplier's fixed latency, then returns the result and exception flags with requester id and tag over a valid/ready response channel. It sits between the two client pipelines and the shift-add multiplier core.

---
 rtl/fpmul_rr_sched.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/fpmul_rr_sched.sv
`timescale 1ns/1ps
// Round-robin scheduler sharing one fixed-latency FP multiplier between two requesters.
// An accepted operand pair is issued with a one-cycle mul_start and its product is returned with id/tag.
module fpmul_rr_sched #(
  parameter int MUL_LAT = 25,
  parameter int TAG_W   = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic [TAG_W-1:0] req1_tag,
  output logic [31:0]      mul_a,
  output logic [31:0]      mul_b,
  output logic             mul_start,
  input  logic [31:0]      mul_result,
  input  logic             mul_ovf,
  input  logic             mul_unf,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_result,
  output logic             rsp_ovf,
  output logic             rsp_unf,
  output logic             busy,
  output logic [1:0]       dbg_state,
  output logic             dbg_prio
);

  // Valid/ready: a transfer happens at a rising CLK edge where valid && ready are both high;
  // the sender holds its payload stable while valid && !ready, and ready never depends on payload.

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_RESP = 2'd3;

  localparam int              CNT_W    = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MUL_LAT - 1);

  logic [1:0]       state;
  logic             prio;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      op_a;
  logic [31:0]      op_b;
  logic [TAG_W-1:0] op_tag;
  logic             op_id;
  logic [31:0]      res_value;
  logic             res_ovf;
  logic             res_unf;

  logic idle;
  logic grant;
  logic hs0;
  logic hs1;

  assign idle = (state == S_IDLE);

  // prio only breaks ties; a lone requester is always granted.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = prio;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign req0_ready = idle && RST && req0_valid && !grant;
  assign req1_ready = idle && RST && req1_valid && grant;
  assign hs0        = req0_valid && req0_ready;
  assign hs1        = req1_valid && req1_ready;

  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= S_IDLE;
      prio      <= 1'b0;
      cnt       <= '0;
      op_a      <= '0;
      op_b      <= '0;
      op_tag    <= '0;
      op_id     <= 1'b0;
      res_value <= '0;
      res_ovf   <= 1'b0;
      res_unf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (hs0 || hs1) begin
            op_a   <= hs1 ? req1_a : req0_a;
            op_b   <= hs1 ? req1_b : req0_b;
            op_tag <= hs1 ? req1_tag : req0_tag;
            op_id  <= hs1;
            prio   <= hs0;
            state  <= S_LOAD;
          end
        end
        S_LOAD: begin
          cnt   <= CNT_INIT;
          state <= S_WAIT;
        end
        S_WAIT: begin
          // cnt==0 is the cycle the multiplier output is valid.
          if (cnt == '0) begin
            res_value <= mul_result;
            res_ovf   <= mul_ovf;
            res_unf   <= mul_unf;
            state     <= S_RESP;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign mul_a      = op_a;
  assign mul_b      = op_b;
  assign mul_start  = (state == S_LOAD);
  assign rsp_valid  = (state == S_RESP);
  assign rsp_id     = op_id;
  assign rsp_tag    = op_tag;
  assign rsp_result = res_value;
  assign rsp_ovf    = res_ovf;
  assign rsp_unf    = res_unf;
  assign busy       = !idle;
  assign dbg_state  = state;
  assign dbg_prio   = prio;

endmodule
